// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and holds
// each fetched word for decode until execute retires it with `advance`.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        is_jump,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        jump_reg,
    input  logic [31:0] jump_target,
    input  logic [25:0] addr26,
    input  logic [15:0] imm16,
    output logic        misalign,
    output logic [1:0]  fsm_state
);

    // Memory handshake: a read completes on any cycle where imem_req and imem_ack are both
    // high; imem_req/imem_addr stay stable until then and ack is meaningless while req is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        take_word;
    logic        retire;
    logic        misalign_next;

    assign imem_addr  = pc;
    assign pc_plus4   = instr_pc + 32'd4;
    assign fsm_state  = state;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        take_word   = 1'b0;
        retire      = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    take_word  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (advance) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // In HOLD pc equals instr_pc, so pc_plus4 is the sequential successor.
    always_comb begin
        next_pc       = pc_plus4;
        misalign_next = 1'b0;
        if (is_jump && jump_reg) begin
            next_pc       = {jump_target[31:2], 2'b00};
            misalign_next = retire && (jump_target[1:0] != 2'b00);
        end else if (is_jump) begin
            next_pc = {pc_plus4[31:28], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            instr_pc    <= RESET_PC;
            misalign    <= 1'b0;
        end else begin
            state    <= state_next;
            misalign <= misalign_next;
            if (take_word) begin
                instruction <= imem_rdata;
                instr_pc    <= pc;
            end
            if (retire) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory responder with variable wait states and a
// queue of expected fetch addresses derived from a next-PC model of the control inputs.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_FETCH  = 2'd1;
    localparam logic [1:0]  S_HOLD   = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [25:0] addr26 = 26'h0;
    logic [15:0] imm16 = 16'h0;
    logic        misalign;
    logic [1:0]  fsm_state;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_pass = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
        .pc_plus4(pc_plus4), .advance(advance), .is_jump(is_jump), .is_branch(is_branch),
        .branch_taken(branch_taken), .jump_reg(jump_reg), .jump_target(jump_target),
        .addr26(addr26), .imm16(imm16), .misalign(misalign), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // One memory access with `waits` wait states; starts at a negedge in FETCH.
    task automatic do_fetch(input int waits);
        logic [31:0] exp_addr;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            exp_addr = 32'h0;
        end else begin
            exp_addr = exp_q.pop_front();
        end
        for (int w = 0; w <= waits; w++) begin
            check("fetch_req", {31'b0, imem_req}, 32'd1);
            check("fetch_addr", imem_addr, exp_addr);
            check("fetch_valid_low", {31'b0, instr_valid}, 32'd0);
            imem_ack   = (w == waits);
            imem_rdata = (w == waits) ? mem_word(exp_addr) : $urandom;
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        model_pc   = exp_addr;
        check("hold_state", {30'b0, fsm_state}, {30'b0, S_HOLD});
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_req_low", {31'b0, imem_req}, 32'd0);
        check("hold_instr", instruction, mem_word(exp_addr));
        check("hold_instr_pc", instr_pc, exp_addr);
        check("hold_pc_plus4", pc_plus4, exp_addr + 32'd4);
        check("misalign_one_cycle", {31'b0, misalign}, 32'd0);
    endtask

    // Present control inputs in HOLD, stall `stall` cycles (with stray acks), then advance.
    task automatic do_advance(input logic j, input logic jr, input logic br, input logic tk,
                              input logic [25:0] a26, input logic [15:0] i16,
                              input logic [31:0] jt, input int stall);
        logic [31:0] p4;
        logic [31:0] nxt;
        logic        mis;
        is_jump = j; jump_reg = jr; is_branch = br; branch_taken = tk;
        addr26 = a26; imm16 = i16; jump_target = jt;
        for (int s = 0; s < stall; s++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            @(negedge clk);
            check("stall_instr_held", instruction, mem_word(model_pc));
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;
        p4  = model_pc + 32'd4;
        mis = 1'b0;
        if (j && jr) begin
            nxt = jt & 32'hFFFF_FFFC;
            mis = (jt[1:0] != 2'b00);
        end else if (j) begin
            nxt = {p4[31:28], a26, 2'b00};
        end else if (br && tk) begin
            nxt = p4 + 32'(signed'(i16)) * 32'd4;
        end else begin
            nxt = p4;
        end
        exp_q.push_back(nxt);
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        check("adv_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
        check("adv_valid_low", {31'b0, instr_valid}, 32'd0);
        check("adv_misalign", {31'b0, misalign}, {31'b0, mis});
        is_jump = 1'b0; jump_reg = 1'b0; is_branch = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, {30'b0, fsm_state}, {30'b0, S_IDLE});
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
        check({tag, "_instr"}, instruction, 32'h0);
        check({tag, "_instr_pc"}, instr_pc, RESET_PC);
        check({tag, "_addr"}, imem_addr, RESET_PC);
        check({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        // Reset, with advance asserted to show it is ignored outside HOLD.
        advance = 1'b1;
        repeat (3) @(negedge clk);
        advance = 1'b0;
        check_reset_outputs("reset");
        reset = 1'b0;
        exp_q.push_back(RESET_PC);
        @(negedge clk);

        // Zero-wait sequential fetches: 0, 4, 8.
        do_fetch(0);
        do_advance(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1);
        do_fetch(0);
        do_advance(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
        do_fetch(0);
        // Three wait states on the next access.
        do_advance(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
        do_fetch(3);
        // Jump to 0x100, branch to self, untaken branch to 0x104.
        do_advance(1, 0, 0, 0, 26'h40, 16'h0, 32'h0, 0);
        do_fetch(1);
        do_advance(0, 0, 1, 1, 26'h0, 16'hFFFF, 32'h0, 0);
        do_fetch(0);
        do_advance(0, 0, 1, 0, 26'h0, 16'hFFFF, 32'h0, 2);
        do_fetch(0);
        // Register jump to 0x1000_0010, region jump, misaligned register jump.
        do_advance(1, 1, 0, 0, 26'h0, 16'h0, 32'h1000_0010, 0);
        do_fetch(0);
        do_advance(1, 0, 0, 0, 26'h40, 16'h0, 32'h0, 0);
        do_fetch(2);
        do_advance(1, 1, 1, 1, 26'h3FF_FFFF, 16'h7FFF, 32'h0000_0203, 0);
        do_fetch(0);
        // PC wrap: 0xFFFF_FFFC + 4 -> 0, then branch backwards across zero.
        do_advance(1, 1, 0, 0, 26'h0, 16'h0, 32'hFFFF_FFFC, 0);
        do_fetch(0);
        do_advance(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
        do_fetch(0);
        do_advance(0, 0, 1, 1, 26'h0, 16'hFFFE, 32'h0, 0);
        do_fetch(0);

        // Random control mix and wait states.
        for (int i = 0; i < 12; i++) begin
            do_advance(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       26'($urandom), 16'($urandom), $urandom, $urandom_range(0, 2));
            do_fetch($urandom_range(0, 3));
        end

        // Reset mid-FETCH with a late ack while in IDLE.
        do_advance(0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 0);
        imem_ack = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_reset_outputs("midfetch_reset");
        reset = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("late_ack_instr", instruction, 32'h0);
        check("late_ack_state", {30'b0, fsm_state}, {30'b0, S_FETCH});
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        do_fetch(1);

        // Reset and advance together in HOLD: reset wins.
        do_advance(1, 0, 0, 0, 26'h123, 16'h0, 32'h0, 0);
        do_fetch(0);
        reset   = 1'b1;
        advance = 1'b1;
        is_jump = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        advance = 1'b0;
        is_jump = 1'b0;
        check_reset_outputs("reset_vs_advance");
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        @(negedge clk);
        do_fetch(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
